// File: rtl/ahb_lite_slave_mux.sv
// AHB-Lite slave-side address decoder and response multiplexer for one master and N_SLAVE slaves.
// Includes an ERROR-only default slave, a stalled-slave watchdog and an ERROR response counter.
module ahb_lite_slave_mux #(
  parameter int                          N_SLAVE        = 4,
  parameter int                          W_ADDR         = 32,
  parameter int                          W_DATA         = 32,
  parameter int                          W_BURST        = 3,
  parameter logic [N_SLAVE*W_ADDR-1:0]   ADDR_START_MAP = '0,
  parameter logic [N_SLAVE*W_ADDR-1:0]   ADDR_MASK      = '0,
  parameter int                          TIMEOUT        = 16
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic                           ma_HSEL,
  input  logic [W_ADDR-1:0]              ma_HADDR,
  input  logic [1:0]                     ma_HTRANS,
  input  logic                           ma_HWRITE,
  input  logic [2:0]                     ma_HSIZE,
  input  logic [W_BURST-1:0]             ma_HBURST,
  input  logic [W_DATA-1:0]              ma_HWDATA,
  output logic                           out_ma_HREADY,
  output logic [1:0]                     out_ma_HRESP,
  output logic [W_DATA-1:0]              out_ma_HRDATA,
  output logic [N_SLAVE-1:0]             out_sl_HSEL,
  output logic [W_ADDR-1:0]              out_sl_HADDR,
  output logic [1:0]                     out_sl_HTRANS,
  output logic                           out_sl_HWRITE,
  output logic [2:0]                     out_sl_HSIZE,
  output logic [W_BURST-1:0]             out_sl_HBURST,
  output logic [W_DATA-1:0]              out_sl_HWDATA,
  output logic                           out_sl_HREADY,
  input  logic [N_SLAVE-1:0]             sl_HREADY,
  input  logic [N_SLAVE*2-1:0]           sl_HRESP,
  input  logic [N_SLAVE*W_DATA-1:0]      sl_HRDATA,
  output logic                           o_timeout,
  output logic [7:0]                     o_err_cnt
);

  // Default-slave FSM
  //   state  | meaning
  //   D_IDLE | default slave not owning the data phase
  //   D_ERR1 | first ERROR cycle, HREADY low
  //   D_ERR2 | second ERROR cycle, HREADY high (transfer completes)

  localparam int         W_IDX      = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
  localparam int         W_CNT      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {OWN_NONE, OWN_SLV, OWN_DEF} own_t;
  typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_t;

  own_t             r_own;
  logic [W_IDX-1:0] r_own_idx;
  dstate_t          r_dstate;
  logic [W_CNT-1:0] r_stall_cnt;
  logic             r_hung;
  logic [W_IDX-1:0] r_hung_idx;
  logic             r_timeout;
  logic [7:0]       r_err_cnt;

  logic             w_hit_any;
  logic [W_IDX-1:0] w_hit_idx;
  logic             w_route_slv;
  logic             w_xfer;
  logic             w_accept;
  logic             w_stall;
  logic             w_abort;
  logic             w_err_beat;
  logic [N_SLAVE-1:0] w_sel;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_idx = '0;
    for (int i = N_SLAVE - 1; i >= 0; i--) begin
      if ((ma_HADDR & ADDR_MASK[i*W_ADDR +: W_ADDR]) ==
          (ADDR_START_MAP[i*W_ADDR +: W_ADDR] & ADDR_MASK[i*W_ADDR +: W_ADDR])) begin
        w_hit_any = 1'b1;
        w_hit_idx = W_IDX'(i);
      end
    end
  end

  assign w_route_slv = w_hit_any && !(r_hung && (r_hung_idx == w_hit_idx));
  assign w_xfer      = ma_HSEL && ma_HTRANS[1];

  always_comb begin
    w_sel = '0;
    if (ma_HSEL && w_route_slv && !HRESET) begin
      w_sel[w_hit_idx] = 1'b1;
    end
  end

  always_comb begin
    out_ma_HREADY = 1'b1;
    out_ma_HRESP  = RESP_OKAY;
    out_ma_HRDATA = '0;
    case (r_own)
      OWN_SLV: begin
        out_ma_HREADY = sl_HREADY[r_own_idx];
        out_ma_HRESP  = sl_HRESP[int'(r_own_idx)*2 +: 2];
        out_ma_HRDATA = sl_HRDATA[int'(r_own_idx)*W_DATA +: W_DATA];
      end
      OWN_DEF: begin
        out_ma_HREADY = (r_dstate == D_ERR2);
        out_ma_HRESP  = RESP_ERROR;
      end
      default: ;
    endcase
  end

  assign w_accept   = out_ma_HREADY;
  assign w_stall    = (r_own == OWN_SLV) && !sl_HREADY[r_own_idx];
  assign w_abort    = (TIMEOUT != 0) && w_stall && (r_stall_cnt == W_CNT'(TIMEOUT - 1));
  assign w_err_beat = out_ma_HREADY && (out_ma_HRESP == RESP_ERROR);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_own     <= OWN_NONE;
      r_own_idx <= '0;
      r_dstate  <= D_IDLE;
    end else if (w_abort) begin
      r_own    <= OWN_DEF;
      r_dstate <= D_ERR1;
    end else begin
      if (w_accept) begin
        if (w_xfer) begin
          r_own     <= w_route_slv ? OWN_SLV : OWN_DEF;
          r_own_idx <= w_hit_idx;
        end else begin
          r_own <= OWN_NONE;
        end
      end
      if (w_accept && w_xfer && !w_route_slv) begin
        r_dstate <= D_ERR1;
      end else begin
        case (r_dstate)
          D_ERR1:  r_dstate <= D_ERR2;
          default: r_dstate <= D_IDLE;
        endcase
      end
    end
  end

  // Abort takes priority over hung release so the fence is always set first.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_stall_cnt <= '0;
      r_hung      <= 1'b0;
      r_hung_idx  <= '0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_timeout <= w_abort;
      if (w_stall && !w_abort && (TIMEOUT != 0)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end else begin
        r_stall_cnt <= '0;
      end
      if (w_abort) begin
        r_hung     <= 1'b1;
        r_hung_idx <= r_own_idx;
      end else if (r_hung && sl_HREADY[r_hung_idx]) begin
        r_hung <= 1'b0;
      end
      if (w_err_beat && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign out_sl_HSEL   = w_sel;
  assign out_sl_HADDR  = ma_HADDR;
  assign out_sl_HTRANS = ma_HTRANS;
  assign out_sl_HWRITE = ma_HWRITE;
  assign out_sl_HSIZE  = ma_HSIZE;
  assign out_sl_HBURST = ma_HBURST;
  assign out_sl_HWDATA = ma_HWDATA;
  assign out_sl_HREADY = out_ma_HREADY;
  assign o_timeout     = r_timeout;
  assign o_err_cnt     = r_err_cnt;

endmodule
